lif_neuron_core: RTL and testbench
==================================

Name: lif_neuron_core

Overview:
- Leaky integrate-and-fire neuron that consumes the signed synaptic sum produced by the binary-weight multiplier/accumulator (popcount(x&w) − popcount(x&~w)).
- One result in, event-driven: leak, integrate, threshold, spike, then a refractory hold.
- Sits directly downstream of the MAC; spike output feeds the next layer's x vector or the scan-out logic.

Parameters:
- N_STAGE, 6, MAC tree depth; y_in is N_STAGE+2 bits, range ±2**N_STAGE
- MEM_W, 16, membrane potential width, signed two's complement
- LEAK_SHIFT, 3, leak = mem >>> LEAK_SHIFT (arithmetic), 0 = full decay each event
- REFRAC, 4, refractory length in cycles; 0 = none

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- y_valid  in  1  y_in valid this cycle (single-cycle strobe, no backpressure)
- y_in  in  N_STAGE+2  signed synaptic sum from the MAC
- threshold  in  MEM_W-1  unsigned firing threshold, zero-extended; 0 disables firing
- spike_out  out  1  one-cycle spike pulse
- mem_out  out  MEM_W  signed membrane potential register
- refractory  out  1  high while in REFRACTORY
- dropped  out  1  one-cycle pulse: y_valid arrived during REFRACTORY and was discarded
- spike_count  out  16  spikes since reset, wraps 0xFFFF→0

Behaviour:
- Reset (rst=1 at posedge): mem_out=0, spike_out=0, refractory=0, dropped=0, spike_count=0, state=INTEGRATE, refractory counter=0. Reset overrides everything, including mid-refractory.
- States:
  - INTEGRATE: accepts inputs.
  - REFRACTORY: drops inputs; counter decrements each cycle.
- INTEGRATE with y_valid=1:
  - Compute in MEM_W+2 bits: next = mem − (mem >>> LEAK_SHIFT) + sext(y_in).
  - Saturate next to [−2**(MEM_W−1), 2**(MEM_W−1)−1].
- Fire condition: threshold≠0 and sat(next) ≥ threshold (signed compare).
- On fire, at the same clock edge:
  - mem ← sat(next) − threshold (reset by subtraction; cannot overflow).
  - spike_out=1 for exactly one cycle.
  - spike_count+1.
  - If REFRAC>0: counter ← REFRAC, state → REFRACTORY.
- No fire: mem ← sat(next).
- INTEGRATE with y_valid=0: mem holds; there is no leak without an event.
- Latency: y_valid at edge k updates mem_out/spike_out visible after edge k; one-cycle registered.
- REFRACTORY:
  - refractory=1; mem holds.
  - y_valid=1 → dropped=1 next cycle and the input is lost.
  - Counter decrements each cycle; at the edge where it goes 1→0, state → INTEGRATE.
  - An input arriving in the cycle after that edge is accepted.
  - Exactly REFRAC cycles are blocked.
- REFRAC=0: never enters REFRACTORY; back-to-back fires are allowed on consecutive valids.
- Leak rounding: arithmetic shift floors, so mem=−1 leaks to 0 and mem=7 (shift 3) stays 7. This is intentional.
- threshold changes take effect on the next evaluated event; no latching.
- y_in of −2**N_STAGE to +2**N_STAGE is all legal.

Decomposition:
- Shared package lif_pkg:
  - state enum {ST_INTEGRATE, ST_REFRACTORY}
  - saturate function (width-parameterised)
  - SPIKE_CNT_W=16 constant
- One natural sub-module, lif_membrane_update: combinational leak + integrate + saturate + fire compare, returning next_mem and fire. The FSM, counters and output registers stay in lif_neuron_core.

Test Plan:
- Reset: drive rst 2 cycles with y_valid=1, y_in=+40 → mem_out=0, spike_out=0, spike_count=0, refractory=0 after release.
- Integrate/fire, threshold=100, REFRAC=2:
  - y_in=+40 ×3 on consecutive cycles → mem 40, 75, then 106≥100.
  - Result: spike_out=1 one cycle, mem_out=6, spike_count=1, refractory=1 for exactly 2 cycles.
- Refractory drop: fire as above, then y_in=+64 on both refractory cycles → dropped=1 each, mem_out stays 6. Next-cycle y_in=+10 → mem 6−0+10=16.
- Negative/leak, threshold=100: y_in=−64 ×2 → mem −64, −120. Then y_valid with y_in=0 → −120−(−15)=−105. No spike.
- Saturation, MEM_W=8, threshold=0, LEAK_SHIFT=3: y_in=+64 ×3 → 64, 120, 169→127. spike_out never asserts.
- Reset mid-refractory: assert rst on the first refractory cycle → state INTEGRATE, counter 0, mem_out=0. Next y_in=+40 is accepted (mem=40, dropped=0).

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron.
package lif_pkg;

  typedef enum logic [0:0] {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } lif_state_e;

  localparam int SPIKE_CNT_W = 16;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  // 'width' must be a constant between 2 and 31 at every call site.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                  input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (val > max_v)      saturate = max_v;
    else if (val < min_v) saturate = min_v;
    else                  saturate = val;
  endfunction

endpackage

// File: rtl/lif_neuron_core_if.sv
// Input strobe, threshold and observable outputs of one neuron.
interface lif_neuron_core_if #(
  parameter int N_STAGE = 6,
  parameter int MEM_W   = 16
);
  import lif_pkg::*;

  logic                         y_valid;
  logic signed [N_STAGE+1:0]    y_in;
  logic        [MEM_W-2:0]      threshold;
  logic                         spike_out;
  logic signed [MEM_W-1:0]      mem_out;
  logic                         refractory;
  logic                         dropped;
  logic        [SPIKE_CNT_W-1:0] spike_count;

  modport master (
    output y_valid, y_in, threshold,
    input  spike_out, mem_out, refractory, dropped, spike_count
  );

  modport slave (
    input  y_valid, y_in, threshold,
    output spike_out, mem_out, refractory, dropped, spike_count
  );
endinterface

// File: rtl/lif_membrane_update.sv
// Combinational leak, integrate, saturate and fire compare for one event.
module lif_membrane_update
  import lif_pkg::*;
#(
  parameter int N_STAGE    = 6,
  parameter int MEM_W      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [MEM_W-1:0]   mem_i,
  input  logic signed [N_STAGE+1:0] y_i,
  input  logic        [MEM_W-2:0]   threshold_i,
  output logic signed [MEM_W-1:0]   next_mem_o,
  output logic                      fire_o
);

  localparam int EXT_W = MEM_W + 2;

  logic signed [EXT_W-1:0] mem_x;
  logic signed [EXT_W-1:0] leak_x;
  logic signed [EXT_W-1:0] y_x;
  logic signed [EXT_W-1:0] sum_x;
  logic signed [31:0]      sat_x;
  logic signed [MEM_W-1:0] thr_s;

  // Two guard bits make mem - leak + y overflow-free before clamping.
  assign mem_x  = {{2{mem_i[MEM_W-1]}}, mem_i};
  assign y_x    = {{(EXT_W-N_STAGE-2){y_i[N_STAGE+1]}}, y_i};
  assign leak_x = mem_x >>> LEAK_SHIFT;
  assign sum_x  = mem_x - leak_x + y_x;
  assign sat_x  = saturate(32'(sum_x), MEM_W);

  assign next_mem_o = sat_x[MEM_W-1:0];
  assign thr_s      = {1'b0, threshold_i};
  assign fire_o     = (threshold_i != '0) && (next_mem_o >= thr_s);

endmodule

// File: rtl/lif_neuron_core.sv
// Event-driven LIF neuron: integrate on each valid sum, fire, then hold off.
//   state          | meaning
//   ST_INTEGRATE   | accepting y_valid events, membrane evolves
//   ST_REFRACTORY  | inputs dropped, hold-off counter running down
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int N_STAGE    = 6,
  parameter int MEM_W      = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 4
) (
  input  logic               clk,
  input  logic               rst,
  lif_neuron_core_if.slave   bus
);

  localparam logic [0:0] S_INTEGRATE  = ST_INTEGRATE;
  localparam logic [0:0] S_REFRACTORY = ST_REFRACTORY;
  localparam int         CNT_W        = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [0:0]              state_q, state_d;
  logic signed [MEM_W-1:0] mem_q, mem_d;
  logic                    spike_q, spike_d;
  logic                    drop_q, drop_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SPIKE_CNT_W-1:0]  scnt_q, scnt_d;

  logic signed [MEM_W-1:0] next_mem;
  logic                    fire;
  logic signed [MEM_W-1:0] thr_ext;

  lif_membrane_update #(
    .N_STAGE    (N_STAGE),
    .MEM_W      (MEM_W),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .mem_i       (mem_q),
    .y_i         (bus.y_in),
    .threshold_i (bus.threshold),
    .next_mem_o  (next_mem),
    .fire_o      (fire)
  );

  assign thr_ext = {1'b0, bus.threshold};

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    spike_d = 1'b0;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    case (state_q)
      S_INTEGRATE: begin
        if (bus.y_valid) begin
          if (fire) begin
            // Reset by subtraction keeps the overshoot above threshold.
            mem_d   = next_mem - thr_ext;
            spike_d = 1'b1;
            scnt_d  = scnt_q + SPIKE_CNT_W'(1);
            if (REFRAC > 0) begin
              cnt_d   = CNT_W'(REFRAC);
              state_d = S_REFRACTORY;
            end
          end else begin
            mem_d = next_mem;
          end
        end
      end
      default: begin
        drop_d = bus.y_valid;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_INTEGRATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INTEGRATE;
      mem_q   <= '0;
      spike_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      spike_q <= spike_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign bus.spike_out   = spike_q;
  assign bus.mem_out     = mem_q;
  assign bus.refractory  = (state_q == S_REFRACTORY);
  assign bus.dropped     = drop_q;
  assign bus.spike_count = scnt_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench: three neuron configurations driven from one initial block.
module tb_lif_neuron_core;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  lif_neuron_core_if #(.N_STAGE(6), .MEM_W(16)) bus_a ();
  lif_neuron_core_if #(.N_STAGE(6), .MEM_W(8))  bus_b ();
  lif_neuron_core_if #(.N_STAGE(6), .MEM_W(16)) bus_c ();

  lif_neuron_core #(.N_STAGE(6), .MEM_W(16), .LEAK_SHIFT(3), .REFRAC(2))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  lif_neuron_core #(.N_STAGE(6), .MEM_W(8), .LEAK_SHIFT(3), .REFRAC(2))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  lif_neuron_core #(.N_STAGE(6), .MEM_W(16), .LEAK_SHIFT(3), .REFRAC(0))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input logic v, input int y);
    bus_a.y_valid = v;
    bus_a.y_in    = 8'(y);
    tick();
  endtask

  task automatic step_b(input logic v, input int y);
    bus_b.y_valid = v;
    bus_b.y_in    = 8'(y);
    tick();
  endtask

  task automatic step_c(input logic v, input int y);
    bus_c.y_valid = v;
    bus_c.y_in    = 8'(y);
    tick();
  endtask

  task automatic do_reset();
    bus_a.y_valid = 1'b0;
    bus_b.y_valid = 1'b0;
    bus_c.y_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fire_a_once();
    bus_a.threshold = 15'd100;
    step_a(1'b1, 40);
    step_a(1'b1, 40);
    step_a(1'b1, 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.y_valid = 1'b1;
    bus_a.y_in    = 8'sd40;
    tick();
    tick();
    rst = 1'b0;
    bus_a.y_valid = 1'b0;
    total_cnt++;
    if (bus_a.mem_out !== 0) $display("FAIL reset_mem: got %0d expected 0", bus_a.mem_out);
    else pass_cnt++;
    total_cnt++;
    if (bus_a.spike_out !== 1'b0) $display("FAIL reset_spike: got %b expected 0", bus_a.spike_out);
    else pass_cnt++;
    total_cnt++;
    if (bus_a.spike_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", bus_a.spike_count);
    else pass_cnt++;
    total_cnt++;
    if (bus_a.refractory !== 1'b0 || bus_a.dropped !== 1'b0)
      $display("FAIL reset_flags: got refr=%b drop=%b expected 0 0", bus_a.refractory, bus_a.dropped);
    else pass_cnt++;
  endtask

  task automatic test_integrate_fire();
    do_reset();
    bus_a.threshold = 15'd100;
    step_a(1'b1, 40);
    total_cnt++;
    if (bus_a.mem_out !== 40 || bus_a.spike_out !== 1'b0)
      $display("FAIL int_1: got mem=%0d spike=%b expected 40 0", bus_a.mem_out, bus_a.spike_out);
    else pass_cnt++;
    step_a(1'b1, 40);
    total_cnt++;
    if (bus_a.mem_out !== 75) $display("FAIL int_2: got %0d expected 75", bus_a.mem_out);
    else pass_cnt++;
    step_a(1'b1, 40);
    total_cnt++;
    if (bus_a.mem_out !== 6 || bus_a.spike_out !== 1'b1 || bus_a.spike_count !== 16'd1 || bus_a.refractory !== 1'b1)
      $display("FAIL fire: got mem=%0d spike=%b cnt=%0d refr=%b expected 6 1 1 1",
               bus_a.mem_out, bus_a.spike_out, bus_a.spike_count, bus_a.refractory);
    else pass_cnt++;
    step_a(1'b0, 0);
    total_cnt++;
    if (bus_a.spike_out !== 1'b0 || bus_a.refractory !== 1'b1)
      $display("FAIL refr_cyc2: got spike=%b refr=%b expected 0 1", bus_a.spike_out, bus_a.refractory);
    else pass_cnt++;
    step_a(1'b0, 0);
    total_cnt++;
    if (bus_a.refractory !== 1'b0 || bus_a.mem_out !== 6)
      $display("FAIL refr_end: got refr=%b mem=%0d expected 0 6", bus_a.refractory, bus_a.mem_out);
    else pass_cnt++;
  endtask

  task automatic test_refractory_drop();
    do_reset();
    fire_a_once();
    step_a(1'b1, 64);
    total_cnt++;
    if (bus_a.dropped !== 1'b1 || bus_a.mem_out !== 6)
      $display("FAIL drop_1: got drop=%b mem=%0d expected 1 6", bus_a.dropped, bus_a.mem_out);
    else pass_cnt++;
    step_a(1'b1, 64);
    total_cnt++;
    if (bus_a.dropped !== 1'b1 || bus_a.mem_out !== 6 || bus_a.refractory !== 1'b0)
      $display("FAIL drop_2: got drop=%b mem=%0d refr=%b expected 1 6 0",
               bus_a.dropped, bus_a.mem_out, bus_a.refractory);
    else pass_cnt++;
    step_a(1'b1, 10);
    total_cnt++;
    if (bus_a.mem_out !== 16 || bus_a.dropped !== 1'b0)
      $display("FAIL after_refr: got mem=%0d drop=%b expected 16 0", bus_a.mem_out, bus_a.dropped);
    else pass_cnt++;
    step_a(1'b0, 0);
    total_cnt++;
    if (bus_a.mem_out !== 16) $display("FAIL hold_no_event: got %0d expected 16", bus_a.mem_out);
    else pass_cnt++;
  endtask

  task automatic test_negative_leak();
    do_reset();
    bus_a.threshold = 15'd100;
    step_a(1'b1, -64);
    total_cnt++;
    if (bus_a.mem_out !== -64) $display("FAIL neg_1: got %0d expected -64", bus_a.mem_out);
    else pass_cnt++;
    step_a(1'b1, -64);
    total_cnt++;
    if (bus_a.mem_out !== -120) $display("FAIL neg_2: got %0d expected -120", bus_a.mem_out);
    else pass_cnt++;
    step_a(1'b1, 0);
    total_cnt++;
    if (bus_a.mem_out !== -105 || bus_a.spike_out !== 1'b0)
      $display("FAIL neg_leak: got mem=%0d spike=%b expected -105 0", bus_a.mem_out, bus_a.spike_out);
    else pass_cnt++;
  endtask

  task automatic test_leak_rounding();
    do_reset();
    bus_a.threshold = 15'd100;
    step_a(1'b1, -1);
    step_a(1'b1, 0);
    total_cnt++;
    if (bus_a.mem_out !== 0) $display("FAIL leak_m1: got %0d expected 0", bus_a.mem_out);
    else pass_cnt++;
    step_a(1'b1, 7);
    step_a(1'b1, 0);
    total_cnt++;
    if (bus_a.mem_out !== 7) $display("FAIL leak_7: got %0d expected 7", bus_a.mem_out);
    else pass_cnt++;
  endtask

  task automatic test_threshold_equal();
    do_reset();
    bus_a.threshold = 15'd40;
    step_a(1'b1, 40);
    total_cnt++;
    if (bus_a.spike_out !== 1'b1 || bus_a.mem_out !== 0)
      $display("FAIL thr_equal: got spike=%b mem=%0d expected 1 0", bus_a.spike_out, bus_a.mem_out);
    else pass_cnt++;
    step_a(1'b0, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    bus_b.threshold = 7'd0;
    step_b(1'b1, 64);
    total_cnt++;
    if (bus_b.mem_out !== 64) $display("FAIL sat_1: got %0d expected 64", bus_b.mem_out);
    else pass_cnt++;
    step_b(1'b1, 64);
    total_cnt++;
    if (bus_b.mem_out !== 120) $display("FAIL sat_2: got %0d expected 120", bus_b.mem_out);
    else pass_cnt++;
    step_b(1'b1, 64);
    total_cnt++;
    if (bus_b.mem_out !== 127 || bus_b.spike_out !== 1'b0)
      $display("FAIL sat_clip: got mem=%0d spike=%b expected 127 0", bus_b.mem_out, bus_b.spike_out);
    else pass_cnt++;
    step_b(1'b0, 0);
    total_cnt++;
    if (bus_b.spike_count !== 16'd0) $display("FAIL thr0_count: got %0d expected 0", bus_b.spike_count);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_c.threshold = 15'd10;
    step_c(1'b1, 20);
    total_cnt++;
    if (bus_c.mem_out !== 10 || bus_c.spike_out !== 1'b1)
      $display("FAIL b2b_1: got mem=%0d spike=%b expected 10 1", bus_c.mem_out, bus_c.spike_out);
    else pass_cnt++;
    step_c(1'b1, 20);
    total_cnt++;
    if (bus_c.mem_out !== 19 || bus_c.spike_out !== 1'b1 || bus_c.spike_count !== 16'd2 || bus_c.refractory !== 1'b0)
      $display("FAIL b2b_2: got mem=%0d spike=%b cnt=%0d refr=%b expected 19 1 2 0",
               bus_c.mem_out, bus_c.spike_out, bus_c.spike_count, bus_c.refractory);
    else pass_cnt++;
    step_c(1'b0, 0);
  endtask

  task automatic test_reset_mid_refractory();
    do_reset();
    fire_a_once();
    rst = 1'b1;
    bus_a.y_valid = 1'b1;
    bus_a.y_in    = 8'sd64;
    tick();
    rst = 1'b0;
    bus_a.y_valid = 1'b0;
    total_cnt++;
    if (bus_a.mem_out !== 0 || bus_a.refractory !== 1'b0 || bus_a.spike_count !== 16'd0 || bus_a.dropped !== 1'b0)
      $display("FAIL rst_mid: got mem=%0d refr=%b cnt=%0d drop=%b expected 0 0 0 0",
               bus_a.mem_out, bus_a.refractory, bus_a.spike_count, bus_a.dropped);
    else pass_cnt++;
    step_a(1'b1, 40);
    total_cnt++;
    if (bus_a.mem_out !== 40 || bus_a.dropped !== 1'b0)
      $display("FAIL rst_mid_accept: got mem=%0d drop=%b expected 40 0", bus_a.mem_out, bus_a.dropped);
    else pass_cnt++;
    step_a(1'b0, 0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus_a.y_valid = 1'b0; bus_a.y_in = '0; bus_a.threshold = 15'd100;
    bus_b.y_valid = 1'b0; bus_b.y_in = '0; bus_b.threshold = 7'd0;
    bus_c.y_valid = 1'b0; bus_c.y_in = '0; bus_c.threshold = 15'd10;
    test_reset();
    test_integrate_fire();
    test_refractory_drop();
    test_negative_leak();
    test_leak_rounding();
    test_threshold_equal();
    test_saturation();
    test_back_to_back();
    test_reset_mid_refractory();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
